// File: rtl/amm2axi4lite_bridge_if.sv
// Avalon-MM slave / AXI4-Lite master signal bundle for the bridge.
// slave: bridge view (Avalon slave + AXI master); master: environment view.
interface amm2axi4lite_bridge_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] s_address;
  logic [3:0]        s_byteenable;
  logic [31:0]       s_writedata;
  logic              s_read;
  logic              s_write;
  logic              s_waitrequest;
  logic [31:0]       s_readdata;
  logic              s_readdatavalid;
  logic              s_resp_err;

  logic [ADDR_W-1:0] m_awaddr;
  logic [2:0]        m_awprot;
  logic              m_awvalid;
  logic              m_awready;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_wvalid;
  logic              m_wready;
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;
  logic [ADDR_W-1:0] m_araddr;
  logic [2:0]        m_arprot;
  logic              m_arvalid;
  logic              m_arready;
  logic [31:0]       m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rvalid;
  logic              m_rready;

  modport slave (
    input  s_address, s_byteenable, s_writedata, s_read, s_write,
    output s_waitrequest, s_readdata, s_readdatavalid, s_resp_err,
    output m_awaddr, m_awprot, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wvalid,
    input  m_wready,
    input  m_bresp, m_bvalid,
    output m_bready,
    output m_araddr, m_arprot, m_arvalid,
    input  m_arready,
    input  m_rdata, m_rresp, m_rvalid,
    output m_rready
  );

  modport master (
    output s_address, s_byteenable, s_writedata, s_read, s_write,
    input  s_waitrequest, s_readdata, s_readdatavalid, s_resp_err,
    input  m_awaddr, m_awprot, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wvalid,
    output m_wready,
    output m_bresp, m_bvalid,
    input  m_bready,
    input  m_araddr, m_arprot, m_arvalid,
    output m_arready,
    output m_rdata, m_rresp, m_rvalid,
    input  m_rready
  );
endinterface

// File: rtl/amm2axi4lite_bridge.sv
// Avalon-MM (readdatavalid) to AXI4-Lite bridge, one transaction in flight.
// Ports: clk, reset (sync, active-high), bus (amm2axi4lite_bridge_if.slave).
module amm2axi4lite_bridge #(
  parameter int       ADDR_W     = 32,
  parameter bit [2:0] AXPROT     = 3'b000,
  parameter bit       FORCE_ALGN = 1'b1
) (
  input logic clk,
  input logic reset,
  amm2axi4lite_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, WREQ, WRSP, WACK, RREQ, RACK, RDAT
  } state_t;

  state_t            r_state, w_state;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [31:0]       r_wdata, w_wdata;
  logic [3:0]        r_strb, w_strb;
  logic              r_awvalid, w_awvalid;
  logic              r_wvalid, w_wvalid;
  logic              r_bready, w_bready;
  logic              r_arvalid, w_arvalid;
  logic              r_rready, w_rready;
  logic [31:0]       r_rdata, w_rdata;
  logic              r_rdv, w_rdv;
  logic              r_err, w_err;
  logic              w_accept;
  logic [ADDR_W-1:0] w_in_addr;

  assign w_in_addr = FORCE_ALGN
    ? {bus.s_address[ADDR_W-1:2], 2'b00}
    : bus.s_address;

  always_comb begin
    w_state   = r_state;
    w_addr    = r_addr;
    w_wdata   = r_wdata;
    w_strb    = r_strb;
    w_awvalid = r_awvalid;
    w_wvalid  = r_wvalid;
    w_bready  = r_bready;
    w_arvalid = r_arvalid;
    w_rready  = r_rready;
    w_rdata   = r_rdata;
    w_rdv     = 1'b0;
    w_err     = 1'b0;
    w_accept  = 1'b0;
    unique case (r_state)
      IDLE: w_accept = 1'b1;
      WREQ: begin
        // AW and W retire independently, in any order
        if (r_awvalid && bus.m_awready)
          w_awvalid = 1'b0;
        if (r_wvalid && bus.m_wready)
          w_wvalid = 1'b0;
        if (!w_awvalid && !w_wvalid) begin
          w_state  = WRSP;
          w_bready = 1'b1;
        end
      end
      WRSP: begin
        if (bus.m_bvalid) begin
          w_bready = 1'b0;
          w_err    = |bus.m_bresp;
          w_state  = WACK;
        end
      end
      WACK: w_state = IDLE;
      RREQ: begin
        if (bus.m_arready) begin
          w_arvalid = 1'b0;
          w_state   = RACK;
        end
      end
      RACK: begin
        // rready held low here so readdatavalid
        // cannot land on the waitrequest-low cycle
        w_rready = 1'b1;
        w_state  = RDAT;
      end
      RDAT: begin
        if (bus.m_rvalid) begin
          w_rready = 1'b0;
          w_rdata  = bus.m_rdata;
          w_rdv    = 1'b1;
          w_err    = |bus.m_rresp;
          w_state  = IDLE;
          w_accept = 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
    if (w_accept) begin
      if (bus.s_write) begin
        w_addr    = w_in_addr;
        w_wdata   = bus.s_writedata;
        w_strb    = bus.s_byteenable;
        w_awvalid = 1'b1;
        w_wvalid  = 1'b1;
        w_state   = WREQ;
      end else if (bus.s_read) begin
        w_addr    = w_in_addr;
        w_arvalid = 1'b1;
        w_state   = RREQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_rdata   <= '0;
      r_rdv     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_strb    <= w_strb;
      r_awvalid <= w_awvalid;
      r_wvalid  <= w_wvalid;
      r_bready  <= w_bready;
      r_arvalid <= w_arvalid;
      r_rready  <= w_rready;
      r_rdata   <= w_rdata;
      r_rdv     <= w_rdv;
      r_err     <= w_err;
    end
  end

  assign bus.s_waitrequest =
    !((r_state == WACK) || (r_state == RACK));
  assign bus.s_readdata      = r_rdata;
  assign bus.s_readdatavalid = r_rdv;
  assign bus.s_resp_err      = r_err;

  assign bus.m_awaddr  = r_addr;
  assign bus.m_awprot  = AXPROT;
  assign bus.m_awvalid = r_awvalid;
  assign bus.m_wdata   = r_wdata;
  assign bus.m_wstrb   = r_strb;
  assign bus.m_wvalid  = r_wvalid;
  assign bus.m_bready  = r_bready;
  assign bus.m_araddr  = r_addr;
  assign bus.m_arprot  = AXPROT;
  assign bus.m_arvalid = r_arvalid;
  assign bus.m_rready  = r_rready;

endmodule

// File: tb/tb_amm2axi4lite_bridge.sv
// Directed bench for amm2axi4lite_bridge.
// Drives Avalon master / AXI slave side by hand, checks each step.
module tb_amm2axi4lite_bridge;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_aw = 0;
  int   n_w = 0;
  int   n_ar = 0;
  int   n_wlow = 0;
  int   n_rdv = 0;
  int   b_aw, b_w, b_ar, b_wlow, b_rdv;

  always #5 clk = ~clk;

  amm2axi4lite_bridge_if #(.ADDR_W(32)) bus ();

  amm2axi4lite_bridge #(
    .ADDR_W(32),
    .AXPROT(3'b000),
    .FORCE_ALGN(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always @(posedge clk) begin
    if (bus.m_awvalid && bus.m_awready) n_aw <= n_aw + 1;
    if (bus.m_wvalid && bus.m_wready) n_w <= n_w + 1;
    if (bus.m_arvalid && bus.m_arready) n_ar <= n_ar + 1;
    if (!bus.s_waitrequest) n_wlow <= n_wlow + 1;
    if (bus.s_readdatavalid) n_rdv <= n_rdv + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h",
             tag, obs, exp);
    end
  endtask

  task automatic snap;
    b_aw = n_aw;
    b_w = n_w;
    b_ar = n_ar;
    b_wlow = n_wlow;
    b_rdv = n_rdv;
  endtask

  initial begin
    bus.s_address = '0;
    bus.s_byteenable = '0;
    bus.s_writedata = '0;
    bus.s_read = 1'b0;
    bus.s_write = 1'b0;
    bus.m_awready = 1'b0;
    bus.m_wready = 1'b0;
    bus.m_bresp = 2'b00;
    bus.m_bvalid = 1'b0;
    bus.m_arready = 1'b0;
    bus.m_rdata = '0;
    bus.m_rresp = 2'b00;
    bus.m_rvalid = 1'b0;

    tick; tick;
    chk("rst_wait", 32'(bus.s_waitrequest), 32'd1);
    chk("rst_rdv", 32'(bus.s_readdatavalid), 32'd0);
    chk("rst_err", 32'(bus.s_resp_err), 32'd0);
    chk("rst_rdata", bus.s_readdata, 32'h0);
    chk("rst_valids",
        {27'd0, bus.m_awvalid, bus.m_wvalid, bus.m_arvalid,
         bus.m_bready, bus.m_rready}, 32'd0);
    reset = 1'b0;
    tick;

    // 1: plain write, zero-wait slave
    bus.s_write = 1'b1;
    bus.s_address = 32'h1000;
    bus.s_writedata = 32'hDEADBEEF;
    bus.s_byteenable = 4'hF;
    bus.m_awready = 1'b1;
    bus.m_wready = 1'b1;
    tick;
    chk("t1_awvalid", 32'(bus.m_awvalid), 32'd1);
    chk("t1_wvalid", 32'(bus.m_wvalid), 32'd1);
    chk("t1_awaddr", bus.m_awaddr, 32'h1000);
    chk("t1_wdata", bus.m_wdata, 32'hDEADBEEF);
    chk("t1_wstrb", 32'(bus.m_wstrb), 32'hF);
    chk("t1_awprot", 32'(bus.m_awprot), 32'd0);
    chk("t1_wait_req", 32'(bus.s_waitrequest), 32'd1);
    tick;
    chk("t1_aw_drop", 32'(bus.m_awvalid), 32'd0);
    chk("t1_bready", 32'(bus.m_bready), 32'd1);
    bus.m_bvalid = 1'b1;
    bus.m_bresp = 2'b00;
    tick;
    chk("t1_wack", 32'(bus.s_waitrequest), 32'd0);
    chk("t1_err", 32'(bus.s_resp_err), 32'd0);
    chk("t1_bready_off", 32'(bus.m_bready), 32'd0);
    bus.s_write = 1'b0;
    bus.m_bvalid = 1'b0;
    tick;
    chk("t1_idle_wait", 32'(bus.s_waitrequest), 32'd1);

    // 2: W completes 3 cycles before AW
    snap;
    bus.s_write = 1'b1;
    bus.s_address = 32'h44;
    bus.s_writedata = 32'h0A0B0C0D;
    bus.s_byteenable = 4'h3;
    bus.m_awready = 1'b0;
    bus.m_wready = 1'b1;
    tick;
    chk("t2_wstrb", 32'(bus.m_wstrb), 32'h3);
    tick;
    chk("t2_w_drop", 32'(bus.m_wvalid), 32'd0);
    chk("t2_aw_hold", 32'(bus.m_awvalid), 32'd1);
    bus.m_wready = 1'b0;
    tick; tick;
    chk("t2_aw_hold2", 32'(bus.m_awvalid), 32'd1);
    chk("t2_still_wait", 32'(bus.s_waitrequest), 32'd1);
    bus.m_awready = 1'b1;
    tick;
    chk("t2_aw_drop", 32'(bus.m_awvalid), 32'd0);
    chk("t2_bready", 32'(bus.m_bready), 32'd1);
    bus.m_awready = 1'b0;
    bus.m_bvalid = 1'b1;
    tick;
    chk("t2_wack", 32'(bus.s_waitrequest), 32'd0);
    bus.s_write = 1'b0;
    bus.m_bvalid = 1'b0;
    tick;
    chk("t2_n_aw", 32'(n_aw - b_aw), 32'd1);
    chk("t2_n_w", 32'(n_w - b_w), 32'd1);
    chk("t2_n_wlow", 32'(n_wlow - b_wlow), 32'd1);

    // 3: read, data 2 cycles after AR
    snap;
    bus.s_read = 1'b1;
    bus.s_address = 32'h2004;
    bus.s_byteenable = 4'h0;
    bus.m_arready = 1'b1;
    tick;
    chk("t3_arvalid", 32'(bus.m_arvalid), 32'd1);
    chk("t3_araddr", bus.m_araddr, 32'h2004);
    chk("t3_wait1", 32'(bus.s_waitrequest), 32'd1);
    tick;
    chk("t3_wait_low", 32'(bus.s_waitrequest), 32'd0);
    chk("t3_ar_drop", 32'(bus.m_arvalid), 32'd0);
    chk("t3_rready_lo", 32'(bus.m_rready), 32'd0);
    bus.s_read = 1'b0;
    bus.m_arready = 1'b0;
    tick;
    chk("t3_wait_hi", 32'(bus.s_waitrequest), 32'd1);
    chk("t3_rready", 32'(bus.m_rready), 32'd1);
    chk("t3_no_rdv", 32'(bus.s_readdatavalid), 32'd0);
    bus.m_rvalid = 1'b1;
    bus.m_rdata = 32'h12345678;
    bus.m_rresp = 2'b00;
    tick;
    chk("t3_rdv", 32'(bus.s_readdatavalid), 32'd1);
    chk("t3_rdata", bus.s_readdata, 32'h12345678);
    chk("t3_err", 32'(bus.s_resp_err), 32'd0);
    chk("t3_rready_off", 32'(bus.m_rready), 32'd0);
    bus.m_rvalid = 1'b0;
    tick;
    chk("t3_rdv_pulse", 32'(bus.s_readdatavalid), 32'd0);
    chk("t3_n_rdv", 32'(n_rdv - b_rdv), 32'd1);
    chk("t3_n_wlow", 32'(n_wlow - b_wlow), 32'd1);

    // 4a: read with SLVERR
    bus.s_read = 1'b1;
    bus.s_address = 32'h10;
    bus.m_arready = 1'b1;
    tick; tick;
    bus.s_read = 1'b0;
    bus.m_arready = 1'b0;
    bus.m_rvalid = 1'b1;
    bus.m_rdata = 32'hCAFEF00D;
    bus.m_rresp = 2'b10;
    tick;
    chk("t4r_no_early", 32'(bus.s_readdatavalid), 32'd0);
    tick;
    chk("t4r_rdv", 32'(bus.s_readdatavalid), 32'd1);
    chk("t4r_rdata", bus.s_readdata, 32'hCAFEF00D);
    chk("t4r_err", 32'(bus.s_resp_err), 32'd1);
    bus.m_rvalid = 1'b0;
    bus.m_rresp = 2'b00;
    tick;
    chk("t4r_err_pulse", 32'(bus.s_resp_err), 32'd0);

    // 4b: write with DECERR
    bus.s_write = 1'b1;
    bus.s_address = 32'h20;
    bus.s_writedata = 32'h1;
    bus.s_byteenable = 4'hF;
    bus.m_awready = 1'b1;
    bus.m_wready = 1'b1;
    tick; tick;
    bus.m_bvalid = 1'b1;
    bus.m_bresp = 2'b11;
    tick;
    chk("t4w_wack", 32'(bus.s_waitrequest), 32'd0);
    chk("t4w_err", 32'(bus.s_resp_err), 32'd1);
    bus.s_write = 1'b0;
    bus.m_bvalid = 1'b0;
    bus.m_bresp = 2'b00;
    tick;
    chk("t4w_err_pulse", 32'(bus.s_resp_err), 32'd0);

    // 5: read+write together, unaligned, wstrb=0
    snap;
    bus.s_write = 1'b1;
    bus.s_read = 1'b1;
    bus.s_address = 32'h3;
    bus.s_writedata = 32'h55AA55AA;
    bus.s_byteenable = 4'h0;
    bus.m_arready = 1'b1;
    tick;
    chk("t5_awvalid", 32'(bus.m_awvalid), 32'd1);
    chk("t5_arvalid", 32'(bus.m_arvalid), 32'd0);
    chk("t5_awaddr", bus.m_awaddr, 32'h0);
    chk("t5_wstrb", 32'(bus.m_wstrb), 32'h0);
    tick;
    bus.m_bvalid = 1'b1;
    tick;
    chk("t5_wack", 32'(bus.s_waitrequest), 32'd0);
    bus.s_write = 1'b0;
    bus.s_read = 1'b0;
    bus.m_bvalid = 1'b0;
    bus.m_arready = 1'b0;
    tick;
    chk("t5_n_ar", 32'(n_ar - b_ar), 32'd0);
    chk("t5_n_aw", 32'(n_aw - b_aw), 32'd1);

    // 6: reset while in RDAT with rvalid pending
    bus.m_awready = 1'b0;
    bus.m_wready = 1'b0;
    bus.s_read = 1'b1;
    bus.s_address = 32'h40;
    bus.m_arready = 1'b1;
    tick; tick;
    bus.s_read = 1'b0;
    bus.m_arready = 1'b0;
    tick;
    chk("t6_rready", 32'(bus.m_rready), 32'd1);
    snap;
    bus.m_rvalid = 1'b1;
    bus.m_rdata = 32'hBAD0BAD0;
    reset = 1'b1;
    tick;
    chk("t6_rready_off", 32'(bus.m_rready), 32'd0);
    chk("t6_rdv", 32'(bus.s_readdatavalid), 32'd0);
    chk("t6_valids",
        {28'd0, bus.m_awvalid, bus.m_wvalid, bus.m_arvalid,
         bus.m_bready}, 32'd0);
    chk("t6_wait", 32'(bus.s_waitrequest), 32'd1);
    bus.m_rvalid = 1'b0;
    reset = 1'b0;
    tick;
    tick;
    chk("t6_idle_ar", 32'(bus.m_arvalid), 32'd0);
    chk("t6_n_rdv", 32'(n_rdv - b_rdv), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
